rvh_mmu_ptw_arbiter: RTL and testbench

- Shares the single page-table-walker (PTW) request port between the ITLB MSHR and the DTLB MSHR.
- Arbitrates each requester's miss-grant stream (valid/ready) round-robin and registers the winner into a one-entry output stage.
- Caps the number of walks in flight.
- Steers each PTW response back to the owning MSHR using a source bit appended to the transaction ID.

---
 rtl/rvh_mmu_ptw_arbiter.sv | 151 +++++++++++++++
 tb/tb_rvh_mmu_ptw_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_mmu_ptw_arbiter.sv
// Shares one page-table-walker request port between the ITLB and DTLB miss queues.
// Round-robin grant into a one-entry output stage, in-flight walk cap, and response steering.
module rvh_mmu_ptw_arbiter #(
  parameter int VPN_WIDTH      = 27,
  parameter int ASID_WIDTH     = 16,
  parameter int TRANS_ID_WIDTH = 4,
  parameter int MAX_INFLIGHT   = 4,
  parameter int CNT_WIDTH      = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,

  input  logic                      itlb_req_vld_i,
  input  logic [TRANS_ID_WIDTH-1:0] itlb_req_trans_id_i,
  input  logic [ASID_WIDTH-1:0]     itlb_req_asid_i,
  input  logic [VPN_WIDTH-1:0]      itlb_req_vpn_i,
  input  logic [1:0]                itlb_req_access_type_i,
  output logic                      itlb_req_rdy_o,

  input  logic                      dtlb_req_vld_i,
  input  logic [TRANS_ID_WIDTH-1:0] dtlb_req_trans_id_i,
  input  logic [ASID_WIDTH-1:0]     dtlb_req_asid_i,
  input  logic [VPN_WIDTH-1:0]      dtlb_req_vpn_i,
  input  logic [1:0]                dtlb_req_access_type_i,
  output logic                      dtlb_req_rdy_o,

  output logic                      ptw_req_vld_o,
  output logic [TRANS_ID_WIDTH:0]   ptw_req_trans_id_o,
  output logic [ASID_WIDTH-1:0]     ptw_req_asid_o,
  output logic [VPN_WIDTH-1:0]      ptw_req_vpn_o,
  output logic [1:0]                ptw_req_access_type_o,
  input  logic                      ptw_req_rdy_i,

  input  logic                      ptw_resp_vld_i,
  input  logic [TRANS_ID_WIDTH:0]   ptw_resp_trans_id_i,

  output logic                      itlb_resp_vld_o,
  output logic [TRANS_ID_WIDTH-1:0] itlb_resp_trans_id_o,
  output logic                      dtlb_resp_vld_o,
  output logic [TRANS_ID_WIDTH-1:0] dtlb_resp_trans_id_o,

  output logic [CNT_WIDTH-1:0]      inflight_cnt_o,
  output logic                      busy_o
);

  logic                      pend_q;
  logic                      rr_ptr_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [TRANS_ID_WIDTH:0]   trans_id_q;
  logic [ASID_WIDTH-1:0]     asid_q;
  logic [VPN_WIDTH-1:0]      vpn_q;
  logic [1:0]                access_type_q;

  logic                      ptw_fire;
  logic                      slot_free;
  logic                      credit_ok;
  logic                      any_vld;
  logic                      admit;
  logic                      winner;
  logic [CNT_WIDTH:0]        occupancy;

  assign ptw_fire  = pend_q & ptw_req_rdy_i;
  assign slot_free = ~pend_q | ptw_fire;

  // Credit is judged on registered state only; a same-cycle response frees credit next cycle.
  assign occupancy = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, pend_q};
  assign credit_ok = occupancy < (CNT_WIDTH + 1)'(MAX_INFLIGHT);

  assign any_vld = itlb_req_vld_i | dtlb_req_vld_i;
  assign admit   = slot_free & credit_ok & any_vld;

  // winner: 0 = ITLB, 1 = DTLB.
  always_comb begin
    // NOTE: default assignment first so every path drives winner and no latch is inferred.
    winner = 1'b0;
    if (itlb_req_vld_i && dtlb_req_vld_i) begin
      winner = rr_ptr_q;
    end else if (dtlb_req_vld_i) begin
      winner = 1'b1;
    end
  end

  assign itlb_req_rdy_o = admit & ~winner;
  assign dtlb_req_rdy_o = admit &  winner;

  // Output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the payload registers are a handful of flops, not a memory, so they are reset too.
      pend_q        <= 1'b0;
      rr_ptr_q      <= 1'b0;
      trans_id_q    <= '0;
      asid_q        <= '0;
      vpn_q         <= '0;
      access_type_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pend_q <= admit | (pend_q & ~ptw_fire);
      if (admit) begin
        rr_ptr_q <= ~winner;
        if (winner) begin
          trans_id_q    <= {1'b1, dtlb_req_trans_id_i};
          asid_q        <= dtlb_req_asid_i;
          vpn_q         <= dtlb_req_vpn_i;
          access_type_q <= dtlb_req_access_type_i;
        end else begin
          trans_id_q    <= {1'b0, itlb_req_trans_id_i};
          asid_q        <= itlb_req_asid_i;
          vpn_q         <= itlb_req_vpn_i;
          access_type_q <= itlb_req_access_type_i;
        end
      end
    end
  end

  // In-flight walk counter; a stray response with nothing outstanding leaves it at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      case ({ptw_fire, ptw_resp_vld_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign ptw_req_vld_o         = pend_q;
  assign ptw_req_trans_id_o    = trans_id_q;
  assign ptw_req_asid_o        = asid_q;
  assign ptw_req_vpn_o         = vpn_q;
  assign ptw_req_access_type_o = access_type_q;

  assign itlb_resp_vld_o      = ptw_resp_vld_i & ~ptw_resp_trans_id_i[TRANS_ID_WIDTH];
  assign dtlb_resp_vld_o      = ptw_resp_vld_i &  ptw_resp_trans_id_i[TRANS_ID_WIDTH];
  assign itlb_resp_trans_id_o = ptw_resp_trans_id_i[TRANS_ID_WIDTH-1:0];
  assign dtlb_resp_trans_id_o = ptw_resp_trans_id_i[TRANS_ID_WIDTH-1:0];

  assign inflight_cnt_o = cnt_q;
  assign busy_o         = pend_q | (cnt_q != '0);

  resp_with_nothing_inflight: assert property (
    @(posedge clk) disable iff (!rstn) !(ptw_resp_vld_i && (cnt_q == '0))
  );

  cnt_within_cap: assert property (
    @(posedge clk) disable iff (!rstn) ({1'b0, cnt_q} <= (CNT_WIDTH + 1)'(MAX_INFLIGHT))
  );

endmodule

// File: tb/tb_rvh_mmu_ptw_arbiter.sv
// Directed-vector bench for rvh_mmu_ptw_arbiter: one table row per clock cycle,
// plus a hand-written asynchronous reset sequence in the middle of traffic.
module tb_rvh_mmu_ptw_arbiter;

  localparam int VW = 27;
  localparam int AW = 16;
  localparam int TW = 4;
  localparam int CW = 3;

  localparam logic [AW-1:0] ITLB_ASID = 16'hA1A1;
  localparam logic [AW-1:0] DTLB_ASID = 16'hD2D2;

  logic          clk;
  logic          rstn;
  logic          itlb_req_vld_i, dtlb_req_vld_i;
  logic [TW-1:0] itlb_req_trans_id_i, dtlb_req_trans_id_i;
  logic [AW-1:0] itlb_req_asid_i, dtlb_req_asid_i;
  logic [VW-1:0] itlb_req_vpn_i, dtlb_req_vpn_i;
  logic [1:0]    itlb_req_access_type_i, dtlb_req_access_type_i;
  logic          itlb_req_rdy_o, dtlb_req_rdy_o;
  logic          ptw_req_vld_o;
  logic [TW:0]   ptw_req_trans_id_o;
  logic [AW-1:0] ptw_req_asid_o;
  logic [VW-1:0] ptw_req_vpn_o;
  logic [1:0]    ptw_req_access_type_o;
  logic          ptw_req_rdy_i;
  logic          ptw_resp_vld_i;
  logic [TW:0]   ptw_resp_trans_id_i;
  logic          itlb_resp_vld_o, dtlb_resp_vld_o;
  logic [TW-1:0] itlb_resp_trans_id_o, dtlb_resp_trans_id_o;
  logic [CW-1:0] inflight_cnt_o;
  logic          busy_o;

  rvh_mmu_ptw_arbiter dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .itlb_req_vld_i         (itlb_req_vld_i),
    .itlb_req_trans_id_i    (itlb_req_trans_id_i),
    .itlb_req_asid_i        (itlb_req_asid_i),
    .itlb_req_vpn_i         (itlb_req_vpn_i),
    .itlb_req_access_type_i (itlb_req_access_type_i),
    .itlb_req_rdy_o         (itlb_req_rdy_o),
    .dtlb_req_vld_i         (dtlb_req_vld_i),
    .dtlb_req_trans_id_i    (dtlb_req_trans_id_i),
    .dtlb_req_asid_i        (dtlb_req_asid_i),
    .dtlb_req_vpn_i         (dtlb_req_vpn_i),
    .dtlb_req_access_type_i (dtlb_req_access_type_i),
    .dtlb_req_rdy_o         (dtlb_req_rdy_o),
    .ptw_req_vld_o          (ptw_req_vld_o),
    .ptw_req_trans_id_o     (ptw_req_trans_id_o),
    .ptw_req_asid_o         (ptw_req_asid_o),
    .ptw_req_vpn_o          (ptw_req_vpn_o),
    .ptw_req_access_type_o  (ptw_req_access_type_o),
    .ptw_req_rdy_i          (ptw_req_rdy_i),
    .ptw_resp_vld_i         (ptw_resp_vld_i),
    .ptw_resp_trans_id_i    (ptw_resp_trans_id_i),
    .itlb_resp_vld_o        (itlb_resp_vld_o),
    .itlb_resp_trans_id_o   (itlb_resp_trans_id_o),
    .dtlb_resp_vld_o        (dtlb_resp_vld_o),
    .dtlb_resp_trans_id_o   (dtlb_resp_trans_id_o),
    .inflight_cnt_o         (inflight_cnt_o),
    .busy_o                 (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = one clock cycle. Expected registered outputs are the values before the
  // rising edge that ends the row; combinational outputs follow that row's inputs.
  typedef struct {
    logic          iv;
    logic [TW-1:0] iid;
    logic [VW-1:0] ivpn;
    logic          dv;
    logic [TW-1:0] did;
    logic [VW-1:0] dvpn;
    logic          prdy;
    logic          rv;
    logic [TW:0]   rid;
    logic          e_irdy;
    logic          e_drdy;
    logic          e_pv;
    logic [TW:0]   e_pid;
    logic [VW-1:0] e_pvpn;
    logic [CW-1:0] e_cnt;
    logic          e_busy;
    logic          e_irv;
    logic          e_drv;
    logic [TW-1:0] e_rtid;
  } vec_t;

  vec_t vecs [27];
  int   n_vec;
  int   n_fail;

  function automatic vec_t mk(
    input logic iv, input logic [TW-1:0] iid, input logic [VW-1:0] ivpn,
    input logic dv, input logic [TW-1:0] did, input logic [VW-1:0] dvpn,
    input logic prdy, input logic rv, input logic [TW:0] rid,
    input logic e_irdy, input logic e_drdy, input logic e_pv,
    input logic [TW:0] e_pid, input logic [VW-1:0] e_pvpn,
    input logic [CW-1:0] e_cnt, input logic e_busy,
    input logic e_irv, input logic e_drv, input logic [TW-1:0] e_rtid);
    vec_t v;
    v.iv = iv;  v.iid = iid;  v.ivpn = ivpn;
    v.dv = dv;  v.did = did;  v.dvpn = dvpn;
    v.prdy = prdy;  v.rv = rv;  v.rid = rid;
    v.e_irdy = e_irdy;  v.e_drdy = e_drdy;  v.e_pv = e_pv;
    v.e_pid = e_pid;  v.e_pvpn = e_pvpn;  v.e_cnt = e_cnt;  v.e_busy = e_busy;
    v.e_irv = e_irv;  v.e_drv = e_drv;  v.e_rtid = e_rtid;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_row(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    itlb_req_vld_i      = v.iv;
    itlb_req_trans_id_i = v.iid;
    itlb_req_vpn_i      = v.ivpn;
    dtlb_req_vld_i      = v.dv;
    dtlb_req_trans_id_i = v.did;
    dtlb_req_vpn_i      = v.dvpn;
    ptw_req_rdy_i       = v.prdy;
    ptw_resp_vld_i      = v.rv;
    ptw_resp_trans_id_i = v.rid;
    #1;
    check($sformatf("row%0d itlb_rdy", i), 32'(itlb_req_rdy_o), 32'(v.e_irdy));
    check($sformatf("row%0d dtlb_rdy", i), 32'(dtlb_req_rdy_o), 32'(v.e_drdy));
    check($sformatf("row%0d ptw_vld", i), 32'(ptw_req_vld_o), 32'(v.e_pv));
    check($sformatf("row%0d ptw_trans_id", i), 32'(ptw_req_trans_id_o), 32'(v.e_pid));
    check($sformatf("row%0d ptw_vpn", i), 32'(ptw_req_vpn_o), 32'(v.e_pvpn));
    check($sformatf("row%0d inflight_cnt", i), 32'(inflight_cnt_o), 32'(v.e_cnt));
    check($sformatf("row%0d busy", i), 32'(busy_o), 32'(v.e_busy));
    check($sformatf("row%0d itlb_resp_vld", i), 32'(itlb_resp_vld_o), 32'(v.e_irv));
    check($sformatf("row%0d dtlb_resp_vld", i), 32'(dtlb_resp_vld_o), 32'(v.e_drv));
    check($sformatf("row%0d itlb_resp_id", i), 32'(itlb_resp_trans_id_o), 32'(v.e_rtid));
    check($sformatf("row%0d dtlb_resp_id", i), 32'(dtlb_resp_trans_id_o), 32'(v.e_rtid));
    if (v.e_pv) begin
      check($sformatf("row%0d ptw_asid", i), 32'(ptw_req_asid_o),
            32'(v.e_pid[TW] ? DTLB_ASID : ITLB_ASID));
      check($sformatf("row%0d ptw_access", i), 32'(ptw_req_access_type_o),
            32'(v.e_pid[TW] ? 2'd2 : 2'd1));
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;

    //           iv iid ivpn      dv did dvpn  prdy rv rid   | irdy drdy pv pid   pvpn      cnt busy irv drv rtid
    vecs[0]  = mk(0, 0, 0,        0, 0, 0,     0,   0, 0,      0, 0, 0, 5'h00, 0,        0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 3, 'h12345,  0, 0, 0,     0,   0, 0,      1, 0, 0, 5'h00, 0,        0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,        0, 0, 0,     1,   0, 0,      0, 0, 1, 5'h03, 'h12345,  0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,        0, 0, 0,     0,   1, 5'h05,  0, 0, 0, 5'h03, 'h12345,  1, 1, 1, 0, 5);
    vecs[4]  = mk(0, 0, 0,        0, 0, 0,     0,   0, 0,      0, 0, 0, 5'h03, 'h12345,  0, 0, 0, 0, 0);
    // Both requesters streaming with the PTW always ready: grants alternate until the cap.
    vecs[5]  = mk(1, 1, 'h111,    1, 2, 'h222, 1,   0, 0,      0, 1, 0, 5'h03, 'h12345,  0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 'h111,    1, 2, 'h222, 1,   0, 0,      1, 0, 1, 5'h12, 'h222,    0, 1, 0, 0, 0);
    vecs[7]  = mk(1, 1, 'h111,    1, 2, 'h222, 1,   0, 0,      0, 1, 1, 5'h01, 'h111,    1, 1, 0, 0, 0);
    vecs[8]  = mk(1, 1, 'h111,    1, 2, 'h222, 1,   0, 0,      1, 0, 1, 5'h12, 'h222,    2, 1, 0, 0, 0);
    vecs[9]  = mk(1, 1, 'h111,    1, 2, 'h222, 1,   0, 0,      0, 0, 1, 5'h01, 'h111,    3, 1, 0, 0, 0);
    vecs[10] = mk(1, 1, 'h111,    1, 2, 'h222, 1,   1, 5'h12,  0, 0, 0, 5'h01, 'h111,    4, 1, 0, 1, 2);
    vecs[11] = mk(1, 1, 'h111,    1, 2, 'h222, 0,   0, 0,      0, 1, 0, 5'h01, 'h111,    3, 1, 0, 0, 0);
    // PTW stalls for five cycles while the requesters change their payloads.
    for (int i = 12; i <= 16; i++)
      vecs[i] = mk(1, 6, 'h666,   1, 7, 'h777, 0,   0, 0,      0, 0, 1, 5'h12, 'h222,    3, 1, 0, 0, 0);
    vecs[17] = mk(1, 1, 'h111,    1, 2, 'h222, 1,   1, 5'h07,  0, 0, 1, 5'h12, 'h222,    3, 1, 1, 0, 7);
    vecs[18] = mk(1, 1, 'h111,    1, 2, 'h222, 1,   0, 0,      1, 0, 0, 5'h12, 'h222,    3, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 0,        0, 0, 0,     0,   0, 0,      0, 0, 1, 5'h01, 'h111,    3, 1, 0, 0, 0);
    // After the mid-traffic reset: ITLB has priority, single requesters win regardless of pointer.
    vecs[20] = mk(1, 1, 'h111,    1, 2, 'h222, 0,   0, 0,      1, 0, 0, 5'h00, 0,        0, 0, 0, 0, 0);
    vecs[21] = mk(1, 4, 'h444,    0, 0, 0,     1,   0, 0,      1, 0, 1, 5'h01, 'h111,    0, 1, 0, 0, 0);
    vecs[22] = mk(0, 0, 0,        1, 9, 'h999, 1,   0, 0,      0, 1, 1, 5'h04, 'h444,    1, 1, 0, 0, 0);
    vecs[23] = mk(0, 0, 0,        0, 0, 0,     1,   1, 5'h14,  0, 0, 1, 5'h19, 'h999,    2, 1, 0, 1, 4);
    vecs[24] = mk(0, 0, 0,        0, 0, 0,     0,   1, 5'h03,  0, 0, 0, 5'h19, 'h999,    2, 1, 1, 0, 3);
    vecs[25] = mk(0, 0, 0,        0, 0, 0,     0,   1, 5'h1f,  0, 0, 0, 5'h19, 'h999,    1, 1, 0, 1, 15);
    vecs[26] = mk(0, 0, 0,        0, 0, 0,     0,   0, 0,      0, 0, 0, 5'h19, 'h999,    0, 0, 0, 0, 0);

    rstn                   = 1'b0;
    itlb_req_vld_i         = 1'b0;
    itlb_req_trans_id_i    = '0;
    itlb_req_asid_i        = ITLB_ASID;
    itlb_req_vpn_i         = '0;
    itlb_req_access_type_i = 2'd1;
    dtlb_req_vld_i         = 1'b0;
    dtlb_req_trans_id_i    = '0;
    dtlb_req_asid_i        = DTLB_ASID;
    dtlb_req_vpn_i         = '0;
    dtlb_req_access_type_i = 2'd2;
    ptw_req_rdy_i          = 1'b0;
    ptw_resp_vld_i         = 1'b0;
    ptw_resp_trans_id_i    = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i <= 19; i++) apply_row(i);

    // Asynchronous reset between clock edges with a buffered request and three walks out.
    @(posedge clk);
    #2;
    check("pre_reset ptw_vld", 32'(ptw_req_vld_o), 32'd1);
    check("pre_reset inflight_cnt", 32'(inflight_cnt_o), 32'd3);
    rstn = 1'b0;
    #1;
    check("async_reset ptw_vld", 32'(ptw_req_vld_o), 32'd0);
    check("async_reset inflight_cnt", 32'(inflight_cnt_o), 32'd0);
    check("async_reset busy", 32'(busy_o), 32'd0);
    check("async_reset itlb_rdy", 32'(itlb_req_rdy_o), 32'd0);
    check("async_reset dtlb_rdy", 32'(dtlb_req_rdy_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 20; i <= 26; i++) apply_row(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
